uart_relay_node: RTL and testbench

- Parametrised ping-pong relay endpoint for the UART link. Sits between an existing UartRx (byte + strobe) and UartTx (data/we/ready) pair.
- Assembles multi-byte words from received bytes, adds a configurable step, and serialises the result back out.
- Initiator mode kicks off the exchange after reset and retransmits on reply timeout.
- Adds a round limit and error/status reporting.

---
 rtl/uart_relay_node.sv | 156 +++++++++++++++
 tb/tb_uart_relay_node.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_relay_node.sv
// Ping-pong relay endpoint: assembles LSB-first words from UartRx,
// adds STEP, and serialises the result back out through UartTx.
module uart_relay_node #(
  parameter int          WORD_BYTES     = 1,
  parameter int          INITIATOR      = 0,
  parameter logic [63:0] INIT_VALUE     = 64'h61,
  parameter int          STEP           = 1,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter int          MAX_ROUNDS     = 0,
  localparam int         W              = 8 * WORD_BYTES
) (
  input  logic         CLK,
  input  logic         RST_X,
  input  logic [7:0]   rx_data,
  input  logic         rx_en,
  output logic [7:0]   tx_data,
  output logic         tx_we,
  input  logic         tx_ready,
  output logic [W-1:0] word_out,
  output logic         word_valid,
  output logic [15:0]  round_cnt,
  output logic [7:0]   retry_cnt,
  output logic         overrun,
  output logic         done
);

  typedef enum logic [2:0] {
    S_INIT, S_RECV, S_SEND, S_GAP, S_DONE
  } state_t;

  localparam logic [2:0]  LAST = 3'(WORD_BYTES - 1);
  localparam logic [31:0] TMO  = 32'(TIMEOUT_CYCLES);

  state_t       r_state;
  state_t       w_next;
  logic [2:0]   r_idx;
  logic [2:0]   r_txi;
  logic [31:0]  r_timer;
  logic [W-1:0] r_asm;
  logic [W-1:0] r_txw;
  logic [W-1:0] w_asm;
  logic [7:0]   w_tx_byte;
  logic [15:0]  w_round_nx;
  logic         w_last_rx;
  logic         w_tmo;
  logic         w_hit;
  logic         w_txlast;

  always_comb begin
    w_asm = r_asm;
    w_asm[r_idx*8 +: 8] = rx_data;
    w_tx_byte = r_txw[r_txi*8 +: 8];
  end

  assign w_last_rx  = rx_en && (r_idx == LAST);
  assign w_tmo      = (TMO != 0) && (r_timer == TMO) && !rx_en;
  assign w_round_nx = (round_cnt == 16'hFFFF) ? round_cnt
                                              : round_cnt + 16'd1;
  assign w_hit      = (MAX_ROUNDS != 0) &&
                      (w_round_nx == 16'(MAX_ROUNDS));
  assign w_txlast   = (r_txi == LAST);

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) r_state <= (INITIATOR != 0) ? S_INIT : S_RECV;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_INIT: w_next = S_SEND;
      S_RECV: begin
        if (w_last_rx)
          w_next = w_hit ? S_DONE : S_SEND;
        else if (w_tmo && INITIATOR != 0)
          w_next = S_SEND;
      end
      S_SEND: if (tx_ready) w_next = S_GAP;
      S_GAP:  w_next = w_txlast ? S_RECV : S_SEND;
      S_DONE: w_next = S_DONE;
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_idx      <= '0;
      r_txi      <= '0;
      r_timer    <= '0;
      r_asm      <= '0;
      r_txw      <= '0;
      tx_data    <= '0;
      tx_we      <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      round_cnt  <= '0;
      retry_cnt  <= '0;
      overrun    <= 1'b0;
      done       <= 1'b0;
    end else begin
      tx_we      <= 1'b0;
      word_valid <= 1'b0;
      if (rx_en && r_state != S_RECV) overrun <= 1'b1;
      unique case (r_state)
        S_INIT: begin
          r_txw <= INIT_VALUE[W-1:0];
          r_txi <= '0;
        end
        S_RECV: begin
          if (rx_en) begin
            r_timer <= '0;
            r_asm   <= w_asm;
            if (w_last_rx) begin
              r_idx      <= '0;
              r_txi      <= '0;
              word_out   <= w_asm;
              word_valid <= 1'b1;
              round_cnt  <= w_round_nx;
              r_txw      <= w_asm + W'(STEP);
              done       <= w_hit;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else if (w_tmo) begin
            // Responder with nothing pending just parks at the limit.
            if (INITIATOR != 0 || r_idx != 0) begin
              r_idx   <= '0;
              r_txi   <= '0;
              r_timer <= '0;
              if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
            end
          end else if (TMO != 0 && r_timer != TMO) begin
            r_timer <= r_timer + 32'd1;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            tx_data <= w_tx_byte;
            tx_we   <= 1'b1;
          end
        end
        S_GAP: begin
          if (w_txlast) begin
            r_idx   <= '0;
            r_timer <= '0;
          end else begin
            r_txi <= r_txi + 3'd1;
          end
        end
        S_DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_relay_node.sv
// Scoreboard bench: initiator, responder and a looped 1-byte pair.
module tb_uart_relay_node;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- DUT A: initiator, 2-byte words
  logic        ra, a_rxen, a_we, a_rdy, a_wv, a_ovr, a_done;
  logic [7:0]  a_rxd, a_txd, a_rty;
  logic [15:0] a_word, a_rnd;
  logic [7:0]  qa_tx[$];
  logic [15:0] qa_w[$];
  logic        a_prev = 1'b0;

  uart_relay_node #(
    .WORD_BYTES(2), .INITIATOR(1), .INIT_VALUE(64'h12FF),
    .STEP(1), .TIMEOUT_CYCLES(200), .MAX_ROUNDS(0)
  ) u_a (
    .CLK(clk), .RST_X(ra), .rx_data(a_rxd), .rx_en(a_rxen),
    .tx_data(a_txd), .tx_we(a_we), .tx_ready(a_rdy),
    .word_out(a_word), .word_valid(a_wv), .round_cnt(a_rnd),
    .retry_cnt(a_rty), .overrun(a_ovr), .done(a_done)
  );

  always @(negedge clk) begin
    if (a_we) begin
      check("a_we_spacing", a_prev, 1'b0);
      if (qa_tx.size() == 0) flag($sformatf("a_tx_unexpected got %h", a_txd));
      else check("a_tx", a_txd, qa_tx.pop_front());
    end
    if (a_wv) begin
      if (qa_w.size() == 0) flag($sformatf("a_word_unexpected got %h", a_word));
      else check("a_word", a_word, qa_w.pop_front());
    end
    a_prev = a_we;
  end

  task automatic push_a(logic [15:0] w);
    qa_tx.push_back(w[7:0]);
    qa_tx.push_back(w[15:8]);
  endtask

  task automatic send_a(logic [7:0] b);
    a_rxd = b;
    a_rxen = 1'b1;
    @(posedge clk);
    #1 a_rxen = 1'b0;
  endtask

  task automatic send_word_a(logic [15:0] w);
    send_a(w[7:0]);
    send_a(w[15:8]);
  endtask

  task automatic wait_a(string nm, int lim);
    int i = 0;
    while (qa_tx.size() != 0 && i < lim) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (qa_tx.size() != 0) begin
      flag($sformatf("%s timeout: %0d bytes pending, required 0", nm, qa_tx.size()));
      qa_tx.delete();
    end
  endtask

  // ---------------- DUT B: responder, 2-byte words, 3 rounds
  logic        rb, b_rxen, b_we, b_rdy, b_wv, b_ovr, b_done;
  logic [7:0]  b_rxd, b_txd, b_rty;
  logic [15:0] b_word, b_rnd;
  logic [7:0]  qb_tx[$];
  logic [15:0] qb_w[$];
  int          n_txb = 0;

  uart_relay_node #(
    .WORD_BYTES(2), .INITIATOR(0), .INIT_VALUE(64'h61),
    .STEP(1), .TIMEOUT_CYCLES(100), .MAX_ROUNDS(3)
  ) u_b (
    .CLK(clk), .RST_X(rb), .rx_data(b_rxd), .rx_en(b_rxen),
    .tx_data(b_txd), .tx_we(b_we), .tx_ready(b_rdy),
    .word_out(b_word), .word_valid(b_wv), .round_cnt(b_rnd),
    .retry_cnt(b_rty), .overrun(b_ovr), .done(b_done)
  );

  always @(negedge clk) begin
    if (b_we) begin
      n_txb++;
      if (qb_tx.size() == 0) flag($sformatf("b_tx_unexpected got %h", b_txd));
      else check("b_tx", b_txd, qb_tx.pop_front());
    end
    if (b_wv) begin
      if (qb_w.size() == 0) flag($sformatf("b_word_unexpected got %h", b_word));
      else check("b_word", b_word, qb_w.pop_front());
    end
  end

  task automatic push_b(logic [15:0] w);
    qb_tx.push_back(w[7:0]);
    qb_tx.push_back(w[15:8]);
  endtask

  task automatic send_b(logic [7:0] b);
    b_rxd = b;
    b_rxen = 1'b1;
    @(posedge clk);
    #1 b_rxen = 1'b0;
  endtask

  task automatic send_word_b(logic [15:0] w);
    send_b(w[7:0]);
    send_b(w[15:8]);
  endtask

  task automatic wait_b(string nm, int lim);
    int i = 0;
    while (qb_tx.size() != 0 && i < lim) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (qb_tx.size() != 0) begin
      flag($sformatf("%s timeout: %0d bytes pending, required 0", nm, qb_tx.size()));
      qb_tx.delete();
    end
  endtask

  // ---------------- C/D: 1-byte loopback pair
  logic       rc, c_we, d_we, c_wv, d_wv, c_ovr, d_ovr, c_done, d_done;
  logic [7:0] c_txd, d_txd, c_word, d_word, c_rty, d_rty;
  logic [15:0] c_rnd, d_rnd;
  logic [7:0] qc[$];
  logic [7:0] qd[$];

  uart_relay_node #(.WORD_BYTES(1), .INITIATOR(1)) u_c (
    .CLK(clk), .RST_X(rc), .rx_data(d_txd), .rx_en(d_we),
    .tx_data(c_txd), .tx_we(c_we), .tx_ready(1'b1),
    .word_out(c_word), .word_valid(c_wv), .round_cnt(c_rnd),
    .retry_cnt(c_rty), .overrun(c_ovr), .done(c_done)
  );

  uart_relay_node #(.WORD_BYTES(1), .INITIATOR(0)) u_d (
    .CLK(clk), .RST_X(rc), .rx_data(c_txd), .rx_en(c_we),
    .tx_data(d_txd), .tx_we(d_we), .tx_ready(1'b1),
    .word_out(d_word), .word_valid(d_wv), .round_cnt(d_rnd),
    .retry_cnt(d_rty), .overrun(d_ovr), .done(d_done)
  );

  always @(negedge clk) begin
    if (c_we) begin
      if (qc.size() == 0) flag($sformatf("c_tx_unexpected got %h", c_txd));
      else check("c_tx", c_txd, qc.pop_front());
    end
    if (d_we) begin
      if (qd.size() == 0) flag($sformatf("d_tx_unexpected got %h", d_txd));
      else check("d_tx", d_txd, qd.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ra = 0; rb = 0; rc = 0;
    a_rxen = 0; a_rxd = 0; a_rdy = 1;
    b_rxen = 0; b_rxd = 0; b_rdy = 1;
    cyc(3);

    // ----- initiator A
    check("a_reset_outs",
      {a_txd, a_we, a_word, a_wv, a_rnd, a_rty, a_ovr, a_done}, 64'h0);
    push_a(16'h12FF);
    ra = 1;
    wait_a("a_init", 50);
    cyc(4);
    check("a_retry_initial", a_rty, 8'd0);
    repeat (3) push_a(16'h12FF);
    wait_a("a_retx", 1000);
    cyc(4);
    check("a_retry_3", a_rty, 8'd3);
    qa_w.push_back(16'h1300);
    push_a(16'h1301);
    send_word_a(16'h1300);
    wait_a("a_late_reply", 50);
    cyc(4);
    check("a_round_1", a_rnd, 16'd1);
    check("a_ovr_clean", a_ovr, 1'b0);
    qa_w.push_back(16'hFFFF);
    push_a(16'h0000);
    send_word_a(16'hFFFF);
    send_a(8'hAA);
    wait_a("a_wrap", 50);
    cyc(4);
    check("a_round_2", a_rnd, 16'd2);
    check("a_ovr_set", a_ovr, 1'b1);
    check("a_retry_kept", a_rty, 8'd3);
    qa_w.push_back(16'h0002);
    qa_tx.push_back(8'h03);
    send_word_a(16'h0002);
    wait_a("a_first_byte", 20);
    ra = 0;
    #1;
    check("a_mid_reset_outs",
      {a_txd, a_we, a_word, a_wv, a_rnd, a_rty, a_ovr, a_done}, 64'h0);
    qa_tx.delete();
    cyc(3);
    push_a(16'h12FF);
    ra = 1;
    wait_a("a_restart", 50);
    cyc(2);
    check("a_restart_state", {a_rnd, a_rty, a_ovr}, 25'h0);
    ra = 0;
    cyc(2);

    // ----- responder B
    check("b_reset_outs",
      {b_txd, b_we, b_word, b_wv, b_rnd, b_rty, b_ovr, b_done}, 64'h0);
    rb = 1;
    cyc(120);
    check("b_idle_no_retry", b_rty, 8'd0);
    send_b(8'h55);
    cyc(110);
    check("b_partial_retry", b_rty, 8'd1);
    b_rdy = 0;
    qb_w.push_back(16'h1234);
    push_b(16'h1235);
    send_word_b(16'h1234);
    cyc(10);
    check("b_holds_for_ready", n_txb, 0);
    b_rdy = 1;
    wait_b("b_round1", 50);
    cyc(4);
    check("b_round_1", b_rnd, 16'd1);
    cyc(150);
    check("b_retry_idle_hold", b_rty, 8'd1);
    qb_w.push_back(16'h12FF);
    push_b(16'h1300);
    send_word_b(16'h12FF);
    wait_b("b_carry", 50);
    cyc(4);
    qb_w.push_back(16'h0001);
    send_word_b(16'h0001);
    cyc(20);
    check("b_done", b_done, 1'b1);
    check("b_round_3", b_rnd, 16'd3);
    check("b_ovr_before", b_ovr, 1'b0);
    send_b(8'h77);
    cyc(2);
    check("b_ovr_in_done", b_ovr, 1'b1);
    check("b_round_frozen", b_rnd, 16'd3);
    check("b_word_frozen", b_word, 16'h0001);
    check("b_tx_total", n_txb, 4);
    rb = 0;
    cyc(2);

    // ----- loopback pair C/D
    for (int i = 0; i < 10; i++) begin
      qc.push_back(8'(8'h61 + 2 * i));
      qd.push_back(8'(8'h62 + 2 * i));
    end
    rc = 1;
    begin
      int i = 0;
      while ((qc.size() != 0 || qd.size() != 0) && i < 500) begin
        @(posedge clk);
        #1;
        i++;
      end
      if (qc.size() != 0 || qd.size() != 0)
        flag($sformatf("cd_loop timeout: %0d/%0d pending, required 0",
                       qc.size(), qd.size()));
    end
    check("c_round", c_rnd, 16'd10);
    check("d_round", d_rnd, 16'd10);
    check("cd_overrun", {c_ovr, d_ovr}, 2'b00);
    rc = 0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
